rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 127 ++++++++++++
 tb/tb_rom_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-master round-robin arbiter in front of a single-port ROM
// with active-low handshake. Master 0 is instruction fetch, master 1 is
// data load. Every access ends in exactly one ack or one err pulse.
// An access is abandoned with err if the ROM stays not-ready too long.
`timescale 1ns/1ps

module rom_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [10:0] m0_addr,
    input  logic        m1_req,
    input  logic [10:0] m1_addr,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rd_data,
    output logic        rom_cs_,
    output logic        rom_as_,
    output logic [10:0] rom_addr,
    input  logic [31:0] rom_rd_data,
    input  logic        rom_rdy_
);

    // Counter holds 0..TIMEOUT-1 and saturates there, so it never wraps.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last;     // master granted most recently
    logic             r_owner;    // master owning the current access
    logic [CNT_W-1:0] r_cnt;
    logic             r_cs_n;
    logic             r_as_n;
    logic [10:0]      r_addr;
    logic [31:0]      r_rd_data;
    logic             r_m0_ack;
    logic             r_m1_ack;
    logic             r_m0_err;
    logic             r_m1_err;

    logic             w_any_req;
    logic             w_pick_m1;
    logic             w_timeout;

    // m1 wins when it is the only requester, or when both request and m0
    // was the last one served.
    assign w_any_req = m0_req | m1_req;
    assign w_pick_m1 = m1_req & (~m0_req | ~r_last);
    assign w_timeout = (r_cnt == CNT_LAST);

    // Grant/access state machine; all outputs come straight from registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
            r_cs_n    <= 1'b1;
            r_as_n    <= 1'b1;
            r_addr    <= '0;
            r_rd_data <= '0;
            r_m0_ack  <= 1'b0;
            r_m1_ack  <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_err  <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // rom_rdy_ is deliberately ignored here: it may still be
                    // low from the access that just finished.
                    if (w_any_req) begin
                        r_addr  <= w_pick_m1 ? m1_addr : m0_addr;
                        r_cs_n  <= 1'b0;
                        r_as_n  <= 1'b0;
                        r_owner <= w_pick_m1;
                        r_last  <= w_pick_m1;
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ready is checked before timeout so it wins a tie.
                    if (!rom_rdy_) begin
                        r_rd_data <= rom_rd_data;
                        r_m0_ack  <= ~r_owner;
                        r_m1_ack  <= r_owner;
                        r_cs_n    <= 1'b1;
                        r_as_n    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_timeout) begin
                        r_m0_err  <= ~r_owner;
                        r_m1_err  <= r_owner;
                        r_cs_n    <= 1'b1;
                        r_as_n    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_err   = r_m0_err;
    assign m1_err   = r_m1_err;
    assign rd_data  = r_rd_data;
    assign rom_cs_  = r_cs_n;
    assign rom_as_  = r_as_n;
    assign rom_addr = r_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed sequence with a behavioural ROM whose
// ready latency is adjustable, and a queue of expected ack/err results.
`timescale 1ns/1ps

module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0;
    logic [10:0] m0_addr = '0;
    logic        m1_req = 1'b0;
    logic [10:0] m1_addr = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] rd_data;
    logic        rom_cs_, rom_as_;
    logic [10:0] rom_addr;
    logic [31:0] rom_rd_data = '0;
    logic        rom_rdy_ = 1'b1;

    logic [31:0] mem [0:2047];
    int          rom_delay = 1;   // 0 = ROM never becomes ready
    int          low_cnt = 0;

    logic [35:0] sb [$];          // {m0_ack, m1_ack, m0_err, m1_err, rd_data}
    logic [31:0] last_data = '0;
    int          n_vec = 0;
    int          n_err = 0;

    rom_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr),
        .m1_req(m1_req), .m1_addr(m1_addr),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err),
        .rd_data(rd_data),
        .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
        .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_)
    );

    always #5 clk = ~clk;

    // Registered ROM: ready goes low rom_delay edges after cs_/as_ seen low.
    always @(posedge clk) begin
        if (!rom_cs_ && !rom_as_) begin
            low_cnt     <= low_cnt + 1;
            rom_rdy_    <= !(rom_delay != 0 && low_cnt + 1 >= rom_delay);
            rom_rd_data <= mem[rom_addr];
        end else begin
            low_cnt  <= 0;
            rom_rdy_ <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ack(input bit m1, input logic [10:0] a);
        last_data = mem[a];
        sb.push_back({!m1, m1, 2'b00, mem[a]});
    endtask

    task automatic push_err(input bit m1);
        sb.push_back({2'b00, !m1, m1, last_data});
    endtask

    // One clock; sample after the edge and score any ack/err that appeared.
    task automatic tick();
        logic [35:0] o;
        logic [35:0] e;
        @(posedge clk);
        #1;
        o = {m0_ack, m1_ack, m0_err, m1_err, rd_data};
        chk("single_pulse", 64'($countones(o[35:32]) <= 1), 64'd1);
        if (o[35:32] != 4'b0000) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", 64'(o), 64'(e));
            end
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        last_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        mem[5] = 32'hDEADBEEF;

        // Reset state
        do_reset();
        chk("rst_cs", 64'(rom_cs_), 64'd1);
        chk("rst_as", 64'(rom_as_), 64'd1);
        chk("rst_addr", 64'(rom_addr), 64'd0);
        chk("rst_rdata", 64'(rd_data), 64'd0);
        chk("rst_flags", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);

        // Single m0 read of word 5
        m0_addr = 11'h005; m0_req = 1'b1; push_ack(1'b0, 11'h005);
        tick();
        chk("t1_cs_c1", 64'(rom_cs_), 64'd0);
        chk("t1_as_c1", 64'(rom_as_), 64'd0);
        chk("t1_addr", 64'(rom_addr), 64'h005);
        tick();
        chk("t1_cs_c2", 64'(rom_cs_), 64'd0);
        tick();
        chk("t1_ack_c3", 64'(m0_ack), 64'd1);
        chk("t1_rdata", 64'(rd_data), 64'hDEADBEEF);
        chk("t1_cs_c3", 64'(rom_cs_), 64'd1);
        m0_req = 1'b0;
        tick();
        chk("t1_no_regrant", 64'(rom_cs_), 64'd1);

        // Both masters requesting continuously from reset: m0,m1,m0,m1
        do_reset();
        m0_addr = 11'h010; m1_addr = 11'h7FF;
        push_ack(1'b0, 11'h010); push_ack(1'b1, 11'h7FF);
        push_ack(1'b0, 11'h010); push_ack(1'b1, 11'h7FF);
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rr_ack_slot", 64'(m0_ack | m1_ack), 64'(k % 3 == 0));
            if (k % 3 == 1) chk("rr_grant_addr", 64'(rom_addr), ((k / 3) % 2 == 0) ? 64'h010 : 64'h7FF);
            if (k == 9) m0_req = 1'b0;
            if (k == 12) m1_req = 1'b0;
        end
        tick();
        chk("rr_idle_after", 64'(rom_cs_), 64'd1);

        // Timeout: ROM never ready, m1 gets err after 8 ACCESS cycles
        rom_delay = 0;
        m1_addr = 11'h123; m1_req = 1'b1; push_err(1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 8) chk("to_cs_low", 64'(rom_cs_), 64'd0);
            if (k == 1) m1_req = 1'b0;
        end
        chk("to_err", 64'(m1_err), 64'd1);
        chk("to_no_ack", 64'(m1_ack), 64'd0);
        chk("to_cs_high", 64'(rom_cs_), 64'd1);
        chk("to_rdata_kept", 64'(rd_data), 64'h0000_0000 | 64'(mem[11'h7FF]));
        tick();

        // Ready arrives in the same cycle the counter hits TIMEOUT-1: ack wins
        rom_delay = 7;
        m0_addr = 11'h0AA; m0_req = 1'b1; push_ack(1'b0, 11'h0AA);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) m0_req = 1'b0;
        end
        chk("tie_ack", 64'(m0_ack), 64'd1);
        chk("tie_no_err", 64'(m0_err), 64'd0);
        tick();

        // Ready one cycle too late: err
        rom_delay = 8;
        m1_addr = 11'h0BB; m1_req = 1'b1; push_err(1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) m1_req = 1'b0;
        end
        chk("late_err", 64'(m1_err), 64'd1);
        tick();
        tick();

        // Reset in the 2nd ACCESS cycle of an m0 access
        rom_delay = 1;
        m0_addr = 11'h005; m0_req = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rstacc_cs", 64'(rom_cs_), 64'd1);
        chk("rstacc_no_ack", 64'(m0_ack), 64'd0);
        chk("rstacc_rdata", 64'(rd_data), 64'd0);
        reset = 1'b0; last_data = '0;
        m0_addr = 11'h044; m1_addr = 11'h055; m1_req = 1'b1;
        push_ack(1'b0, 11'h044); push_ack(1'b1, 11'h055);
        tick();
        chk("rstacc_m0_wins", 64'(rom_addr), 64'h044);
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        chk("rstacc_m1_next", 64'(rom_addr), 64'h055);
        tick();
        tick();
        m1_req = 1'b0;
        chk("rstacc_m1_ack", 64'(m1_ack), 64'd1);

        // m0 drops req right after grant; stale ready in IDLE is ignored
        m0_addr = 11'h321; m0_req = 1'b1; push_ack(1'b0, 11'h321);
        tick();
        m0_req = 1'b0;
        tick();
        tick();
        chk("drop_ack", 64'(m0_ack), 64'd1);
        tick();
        chk("stale_cs", 64'(rom_cs_), 64'd1);
        tick();
        chk("stale_no_ack", 64'({m0_ack, m1_ack}), 64'd0);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
